// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM and MEM/WB control registers with load-use hazard detection,
// EX operand forwarding selects and a saturating load-use stall counter.
module ctrl_pipe #(
    parameter int RA_W   = 5,
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic              RegWriteD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [RA_W-1:0]   RsD,
    input  logic [RA_W-1:0]   RtD,
    input  logic [RA_W-1:0]   RdD,
    input  logic              FlushExt,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic              RegWriteE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [RA_W-1:0]   RsE,
    output logic [RA_W-1:0]   RtE,
    output logic [RA_W-1:0]   WriteRegE,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic              RegWriteM,
    output logic [RA_W-1:0]   WriteRegM,
    output logic              MemtoRegW,
    output logic              RegWriteW,
    output logic [RA_W-1:0]   WriteRegW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  StallCount
);
    logic [RA_W-1:0] rd_e;
    logic            lwstall;

    always_comb begin
        lwstall   = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
        StallF    = lwstall;
        StallD    = lwstall;
        FlushE    = lwstall | FlushExt;
        WriteRegE = RegDstE ? rd_e : RtE;
        ForwardAE = (RsE != '0 && RegWriteM && RsE == WriteRegM) ? 2'b10 :
                    (RsE != '0 && RegWriteW && RsE == WriteRegW) ? 2'b01 : 2'b00;
        ForwardBE = (RtE != '0 && RegWriteM && RtE == WriteRegM) ? 2'b10 :
                    (RtE != '0 && RegWriteW && RtE == WriteRegW) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE, ALUControlE, RsE, RtE, rd_e} <= '0;
            {MemtoRegM, MemWriteM, RegWriteM, WriteRegM} <= '0;
            {MemtoRegW, RegWriteW, WriteRegW} <= '0;
            StallCount <= '0;
        end else begin
            // a flush (load-use or external) turns the E slot into an all-zero bubble
            {MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE, ALUControlE, RsE, RtE, rd_e} <=
                FlushE ? '0 : {MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, RegWriteD, ALUControlD, RsD, RtD, RdD};
            {MemtoRegM, MemWriteM, RegWriteM, WriteRegM} <= {MemtoRegE, MemWriteE, RegWriteE, WriteRegE};
            {MemtoRegW, RegWriteW, WriteRegW} <= {MemtoRegM, RegWriteM, WriteRegM};
            if (lwstall && StallCount != {CNT_W{1'b1}})
                StallCount <= StallCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: randomized stimulus checked every cycle against an instruction-slot model,
// plus directed sequences with hand-computed expectations.
module tb_ctrl_pipe;
    typedef struct packed {
        logic       mtr, mw, br, as, rdst, rw;
        logic [2:0] alu;
        logic [4:0] rs, rt, rd;
    } ins_t;

    logic clk = 0, rst = 1, fext = 0;
    ins_t d = '0;
    always #5 clk = ~clk;

    logic MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE;
    logic [2:0] ALUControlE;
    logic [4:0] RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic MemtoRegM, MemWriteM, RegWriteM, MemtoRegW, RegWriteW, StallF, StallD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    logic s_mtre, s_mwe, s_bre, s_ase, s_rde, s_rwe, s_mtrm, s_mwm, s_rwm, s_mtrw, s_rww, s_sf, s_sd, s_fe;
    logic [2:0] s_alue;
    logic [4:0] s_rse, s_rte, s_wre, s_wrm, s_wrw;
    logic [1:0] s_fa, s_fb;
    logic [1:0] s_cnt;

    ctrl_pipe dut (
        .clk(clk), .reset(rst), .MemtoRegD(d.mtr), .MemWriteD(d.mw), .BranchD(d.br), .ALUSrcD(d.as),
        .RegDstD(d.rdst), .RegWriteD(d.rw), .ALUControlD(d.alu), .RsD(d.rs), .RtD(d.rt), .RdD(d.rd),
        .FlushExt(fext), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .RegWriteE(RegWriteE), .ALUControlE(ALUControlE),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
        .WriteRegW(WriteRegW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF),
        .StallD(StallD), .FlushE(FlushE), .StallCount(StallCount)
    );

    ctrl_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(rst), .MemtoRegD(d.mtr), .MemWriteD(d.mw), .BranchD(d.br), .ALUSrcD(d.as),
        .RegDstD(d.rdst), .RegWriteD(d.rw), .ALUControlD(d.alu), .RsD(d.rs), .RtD(d.rt), .RdD(d.rd),
        .FlushExt(fext), .MemtoRegE(s_mtre), .MemWriteE(s_mwe), .BranchE(s_bre), .ALUSrcE(s_ase),
        .RegDstE(s_rde), .RegWriteE(s_rwe), .ALUControlE(s_alue), .RsE(s_rse), .RtE(s_rte),
        .WriteRegE(s_wre), .MemtoRegM(s_mtrm), .MemWriteM(s_mwm), .RegWriteM(s_rwm),
        .WriteRegM(s_wrm), .MemtoRegW(s_mtrw), .RegWriteW(s_rww), .WriteRegW(s_wrw),
        .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf), .StallD(s_sd), .FlushE(s_fe),
        .StallCount(s_cnt)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    // model: the instruction occupying each of the E, M and W slots
    ins_t e = '0, m = '0, w = '0;
    int cnt = 0, cnt2 = 0;

    function automatic logic [4:0] dest(input ins_t i);
        return i.rdst ? i.rd : i.rt;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] r, input ins_t mm, input ins_t ww);
        if (r == 0) return 2'b00;
        if (mm.rw && dest(mm) == r) return 2'b10;
        if (ww.rw && dest(ww) == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic load_use(input ins_t ee, input ins_t dd);
        return ee.mtr && (ee.rt == dd.rs || ee.rt == dd.rt);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = '0; m = '0; w = '0; cnt = 0; cnt2 = 0;
        end else begin
            if (load_use(e, d)) begin
                if (cnt < 65535) cnt = cnt + 1;
                if (cnt2 < 3) cnt2 = cnt2 + 1;
            end
            w = m;
            m = e;
            e = (load_use(e, d) || fext) ? '0 : d;
        end
    end

    always @(negedge clk) begin
        chk("e_ctrl", {MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE, ALUControlE},
            {e.mtr, e.mw, e.br, e.as, e.rdst, e.rw, e.alu});
        chk("e_regs", {RsE, RtE, WriteRegE}, {e.rs, e.rt, dest(e)});
        chk("m_stage", {MemtoRegM, MemWriteM, RegWriteM, WriteRegM}, {m.mtr, m.mw, m.rw, dest(m)});
        chk("w_stage", {MemtoRegW, RegWriteW, WriteRegW}, {w.mtr, w.rw, dest(w)});
        chk("forward", {ForwardAE, ForwardBE}, {fwd(e.rs, m, w), fwd(e.rt, m, w)});
        chk("hazard", {StallF, StallD, FlushE}, {load_use(e, d), load_use(e, d), load_use(e, d) | fext});
        chk("count", StallCount, cnt);
        chk("count_sat", s_cnt, cnt2);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step; step;
        rst = 0;
        #1 chk("rst_count", StallCount, 0);
        chk("rst_w", {RegWriteW, WriteRegW}, 0);
        // pass-through of one R-type to register 5
        d = '0; d.rdst = 1; d.rw = 1; d.rd = 5; d.alu = 3'b010;
        step; d = '0;
        #1 chk("pt_e", {WriteRegE, ALUControlE}, {5'd5, 3'b010});
        step;
        #1 chk("pt_m", {RegWriteM, WriteRegM}, {1'b1, 5'd5});
        step;
        #1 chk("pt_w", {RegWriteW, WriteRegW}, {1'b1, 5'd5});
        rst = 1;
        #1 chk("rst_mid", {RegWriteW, WriteRegW, RegWriteE, WriteRegE, StallCount}, 0);
        step; rst = 0;
        // load-use on rt = 8
        d = '0; d.mtr = 1; d.rt = 8; d.rs = 1;
        step; d = '0; d.rs = 8;
        #1 chk("lu_hz", {StallF, StallD, FlushE}, 3'b111);
        step;
        #1 chk("lu_bubble", {MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE, ALUControlE}, 0);
        chk("lu_count", StallCount, 1);
        // forwarding priority on register 3
        d = '0; d.rdst = 1; d.rw = 1; d.rd = 3;
        step; step;
        d.rs = 3;
        step; d.rs = 0;
        #1 chk("fwd_mem_pri", ForwardAE, 2'b10);
        step;
        #1 chk("fwd_state", {RegWriteM, WriteRegM, RegWriteW, WriteRegW}, {1'b1, 5'd3, 1'b1, 5'd3});
        chk("fwd_r0", ForwardAE, 2'b00);
        // external flush alone
        d = '0; d.rw = 1; d.rdst = 1; d.rd = 4; fext = 1;
        #1 chk("fx_hz", {StallF, FlushE}, 2'b01);
        step; fext = 0; d = '0;
        #1 chk("fx_bubble", RegWriteE, 0);
        chk("fx_count", StallCount, 1);
        // load-use together with external flush
        d = '0; d.mtr = 1; d.rt = 8;
        step; d = '0; d.rs = 8; fext = 1;
        #1 chk("both_hz", {StallF, StallD, FlushE}, 3'b111);
        step; fext = 0; d = '0;
        #1 chk("both_count", StallCount, 2);
        chk("both_bubble", {MemtoRegE, RegWriteE, RsE, RtE}, 0);
        // saturation of the 2-bit counter
        rst = 1; #1 rst = 0;
        for (int i = 0; i < 5; i++) begin
            d = '0; d.mtr = 1; d.rt = 8; d.rs = 1;
            step; d = '0; d.rs = 8;
            #1 chk("sat_stall", StallF, 1);
            step;
            #1 chk("sat_seq", s_cnt, (i < 3) ? i + 1 : 3);
            chk("sat_wide", StallCount, i + 1);
        end
        // randomized traffic over a small register set to provoke hazards
        repeat (800) begin
            step;
            d.mtr = 1'($urandom_range(0, 1)); d.mw = 1'($urandom_range(0, 1));
            d.br = 1'($urandom_range(0, 1)); d.as = 1'($urandom_range(0, 1));
            d.rdst = 1'($urandom_range(0, 1)); d.rw = 1'($urandom_range(0, 1));
            d.alu = 3'($urandom_range(0, 7));
            d.rs = 5'($urandom_range(0, 3)); d.rt = 5'($urandom_range(0, 3)); d.rd = 5'($urandom_range(0, 3));
            fext = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 99) == 0);
        end
        step; rst = 0;
        step;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decode-stage control bundle (MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, ALUControl plus register addresses).
- Carries that bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers and presents per-stage controls to the datapath.
- Owns load-use hazard detection (stall/flush), EX-stage operand forwarding selects, and a saturating stall-cycle counter.
- Sits between the control unit and the five-stage datapath of the pipeline processor.

Parameters:
- RA_W, 5, register-address width
- ALUC_W, 3, ALUControl width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, RegWriteD  in  1 each  decode-stage controls
- ALUControlD  in  ALUC_W  decode-stage ALU op
- RsD, RtD, RdD  in  RA_W  decode-stage register fields
- FlushExt  in  1  external EX bubble request (taken branch)
- MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE  out  1 each  EX-stage controls
- ALUControlE  out  ALUC_W  EX-stage ALU op
- RsE, RtE, WriteRegE  out  RA_W  EX register fields and destination
- MemtoRegM, MemWriteM, RegWriteM  out  1 each  MEM-stage controls
- WriteRegM  out  RA_W  MEM destination
- MemtoRegW, RegWriteW  out  1 each  WB-stage controls
- WriteRegW  out  RA_W  WB destination
- ForwardAE, ForwardBE  out  2 each  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result
- StallF, StallD, FlushE  out  1 each  hazard controls
- StallCount  out  CNT_W  load-use stall cycles since reset

Behaviour:
- Reset (async, active-high): every E/M/W register, including addresses, goes to 0; StallCount = 0. Combinational outputs therefore evaluate to 0.
- Per clock edge:
  - D->E register captures all D inputs. When FlushE = 1, it loads all zeros instead (bubble).
  - E->M captures MemtoRegE, MemWriteE, RegWriteE and WriteRegE.
  - M->W captures MemtoRegM, RegWriteM and WriteRegM.
  - M and W registers never stall and never flush.
- BranchE is carried for datapath use only; it is not forwarded past E.
- WriteRegE is combinational: RdE when RegDstE = 1, else RtE.
- Latency: a D input appears at E outputs 1 cycle later, at M 2 cycles later, at W 3 cycles later (absent flush).
- Load-use hazard: lwstall = MemtoRegE & ((RtE == RsD) | (RtE == RtD)).
  - StallF = StallD = lwstall.
  - FlushE = lwstall | FlushExt.
  - All combinational from current E registers and D inputs.
- Forwarding, A operand (same rule for B using RtE):
  - ForwardAE = 10 if RsE != 0 & RegWriteM & RsE == WriteRegM.
  - Else 01 if RsE != 0 & RegWriteW & RsE == WriteRegW.
  - Else 00.
  - MEM has priority over WB when both match.
  - Register 0 never forwards.
- StallCount: increments by 1 on each edge where lwstall = 1.
  - Saturates at 2^CNT_W - 1; no wrap.
  - FlushExt alone does not count.
- Simultaneous lwstall and FlushExt: one bubble inserted; count increments once.
- Reset mid-stream: in-flight instructions are discarded; first post-reset D input reaches E on the next edge.

Test Plan:
- Reset asserted mid-operation with RegWriteW = 1 -> all outputs 0 immediately (before next clk), StallCount = 0.
- Pass-through: one D instruction RegDstD = 1, RegWriteD = 1, RdD = 5, ALUControlD = 010, FlushExt = 0 -> E shows WriteRegE = 5, ALUControlE = 010 at +1; WriteRegM = 5 at +2; WriteRegW = 5, RegWriteW = 1 at +3.
- Load-use: E holds lw (MemtoRegE = 1, RtE = 8), D has RsD = 8 -> StallF = StallD = FlushE = 1; next cycle E controls all 0, StallCount = 1.
- Forward priority: RegWriteM = 1, WriteRegM = 3; RegWriteW = 1, WriteRegW = 3; RsE = 3 -> ForwardAE = 10. With RsE = 0 under the same M/W state -> ForwardAE = 00.
- FlushExt = 1 with a valid add in D -> E bubble (RegWriteE = 0), StallF = 0, StallCount unchanged. lwstall and FlushExt together -> single bubble, count +1.
- Saturation: CNT_W = 2, hold lwstall for 5 cycles -> StallCount sequence 1, 2, 3, 3, 3.
